// File: rtl/silly_vector_sequencer.sv
// Stimulus/response sequencer for sillyfunction (y = ~b&~c | ~a&~b): sweeps all
// eight {a,b,c} vectors, samples y after a settle delay and scores it against the truth table.
module silly_vector_sequencer #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned SETTLE      = 1,
    parameter int unsigned NUM_PASSES  = 1,
    parameter int unsigned ERR_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             a,
    output logic             b,
    output logic             c,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [2:0]       first_err_vec,
    output logic             first_err_valid
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FINISH
    } state_e;

    localparam logic [7:0]       HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0]       SETTLE_AT = 8'(SETTLE);
    localparam logic [7:0]       PASS_LAST = 8'(NUM_PASSES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;

    state_e           state_q, state_d;
    logic [2:0]       vec_q, vec_d;
    logic [7:0]       hold_cnt_q, hold_cnt_d;
    logic [7:0]       pass_cnt_q, pass_cnt_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [2:0]       first_err_vec_q, first_err_vec_d;
    logic             first_err_valid_q, first_err_valid_d;
    logic             pass_q, pass_d;

    // Golden truth table: y is high only for vectors 000, 001 and 100.
    function automatic logic golden_y(input logic [2:0] v);
        return (v == 3'b000) || (v == 3'b001) || (v == 3'b100);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= ST_IDLE;
            vec_q             <= '0;
            hold_cnt_q        <= '0;
            pass_cnt_q        <= '0;
            err_count_q       <= '0;
            first_err_vec_q   <= '0;
            first_err_valid_q <= 1'b0;
            pass_q            <= 1'b0;
        end else begin
            state_q           <= state_d;
            vec_q             <= vec_d;
            hold_cnt_q        <= hold_cnt_d;
            pass_cnt_q        <= pass_cnt_d;
            err_count_q       <= err_count_d;
            first_err_vec_q   <= first_err_vec_d;
            first_err_valid_q <= first_err_valid_d;
            pass_q            <= pass_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        vec_d             = vec_q;
        hold_cnt_d        = hold_cnt_q;
        pass_cnt_d        = pass_cnt_q;
        err_count_d       = err_count_q;
        first_err_vec_d   = first_err_vec_q;
        first_err_valid_d = first_err_valid_q;
        pass_d            = pass_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d           = ST_RUN;
                    vec_d             = '0;
                    hold_cnt_d        = '0;
                    pass_cnt_d        = '0;
                    err_count_d       = '0;
                    first_err_valid_d = 1'b0;
                    pass_d            = 1'b0;
                end
            end

            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    pass_d  = 1'b0;
                end else begin
                    if ((hold_cnt_q == SETTLE_AT) && (y != golden_y(vec_q))) begin
                        if (err_count_q != ERR_MAX) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                        if (!first_err_valid_q) begin
                            first_err_vec_d   = vec_q;
                            first_err_valid_d = 1'b1;
                        end
                    end

                    if (hold_cnt_q == HOLD_LAST) begin
                        hold_cnt_d = '0;
                        if (vec_q != 3'd7) begin
                            vec_d = vec_q + 3'd1;
                        end else if (pass_cnt_q != PASS_LAST) begin
                            vec_d      = '0;
                            pass_cnt_d = pass_cnt_q + 8'd1;
                        end else begin
                            // Use the next-state count: with SETTLE == HOLD_CYCLES-1 the
                            // last compare lands on this same cycle.
                            state_d = ST_FINISH;
                            pass_d  = (err_count_d == '0);
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q + 8'd1;
                    end
                end
            end

            ST_FINISH: begin
                state_d = ST_IDLE;
                if (abort) begin
                    pass_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign {a, b, c}       = (state_q == ST_RUN) ? vec_q : 3'b000;
    assign busy            = (state_q == ST_RUN);
    assign done            = (state_q == ST_FINISH) && !abort;
    assign pass            = pass_q;
    assign err_count       = err_count_q;
    assign first_err_vec   = first_err_vec_q;
    assign first_err_valid = first_err_valid_q;

endmodule

// File: tb/tb_silly_vector_sequencer.sv
// Directed bench for silly_vector_sequencer: three instances (defaults, ERR_W=2,
// NUM_PASSES=2) driven by a behavioural sillyfunction with optional stuck-at faults.
module tb_silly_vector_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] start_v;
    logic       abort;
    logic [2:0] y_v;
    int         ymode [3];

    logic       a0, b0, c0, busy0, done0, pass0, fval0;
    logic       a1, b1, c1, busy1, done1, pass1, fval1;
    logic       a2, b2, c2, busy2, done2, pass2, fval2;
    logic [3:0] errc0, errc2;
    logic [1:0] errc1;
    logic [2:0] fev0, fev1, fev2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] errc;
        logic [2:0] fev;
        logic       fvalid;
        logic       pass;
        int         busy_len;
        int         wraps;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    silly_vector_sequencer u_def (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort),
        .a(a0), .b(b0), .c(c0), .y(y_v[0]),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_count(errc0), .first_err_vec(fev0), .first_err_valid(fval0)
    );

    silly_vector_sequencer #(.ERR_W(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort),
        .a(a1), .b(b1), .c(c1), .y(y_v[1]),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(errc1), .first_err_vec(fev1), .first_err_valid(fval1)
    );

    silly_vector_sequencer #(.NUM_PASSES(2)) u_np2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(abort),
        .a(a2), .b(b2), .c(c2), .y(y_v[2]),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_count(errc2), .first_err_vec(fev2), .first_err_valid(fval2)
    );

    function automatic logic [2:0] abc_of(input int i);
        case (i)
            0:       return {a0, b0, c0};
            1:       return {a1, b1, c1};
            default: return {a2, b2, c2};
        endcase
    endfunction

    function automatic logic busy_of(input int i);
        case (i) 0: return busy0; 1: return busy1; default: return busy2; endcase
    endfunction

    function automatic logic done_of(input int i);
        case (i) 0: return done0; 1: return done1; default: return done2; endcase
    endfunction

    function automatic logic pass_of(input int i);
        case (i) 0: return pass0; 1: return pass1; default: return pass2; endcase
    endfunction

    function automatic logic fval_of(input int i);
        case (i) 0: return fval0; 1: return fval1; default: return fval2; endcase
    endfunction

    function automatic logic [2:0] fev_of(input int i);
        case (i) 0: return fev0; 1: return fev1; default: return fev2; endcase
    endfunction

    function automatic logic [3:0] errc_of(input int i);
        case (i) 0: return errc0; 1: return {2'b00, errc1}; default: return errc2; endcase
    endfunction

    // Reference sillyfunction per instance; mode 1/2 model y stuck-at-0/1.
    always_comb begin
        logic [2:0] v;
        y_v = '0;
        for (int i = 0; i < 3; i++) begin
            v = abc_of(i);
            case (ymode[i])
                0:       y_v[i] = (~v[1] & ~v[0]) | (~v[2] & ~v[1]);
                1:       y_v[i] = 1'b0;
                default: y_v[i] = 1'b1;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_all_zero(input string tag, input int i);
        chk({tag, " abc"}, 32'(abc_of(i)), 0);
        chk({tag, " busy"}, 32'(busy_of(i)), 0);
        chk({tag, " done"}, 32'(done_of(i)), 0);
        chk({tag, " pass"}, 32'(pass_of(i)), 0);
        chk({tag, " err_count"}, 32'(errc_of(i)), 0);
        chk({tag, " first_err_vec"}, 32'(fev_of(i)), 0);
        chk({tag, " first_err_valid"}, 32'(fval_of(i)), 0);
    endtask

    // Pulse start, follow the run to its done pulse, then score against the queued expectation.
    task automatic run_check(input int i, input int repulse, input exp_t e, input string tag);
        exp_t       x;
        int         n, wraps, seq_bad;
        bit         got;
        logic [2:0] prev, cur;
        n = 0; wraps = 0; seq_bad = 0; got = 1'b0; prev = 3'd0;
        sb.push_back(e);
        start_v[i] = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 400; k++) begin
            start_v[i] = (k == repulse);
            if (done_of(i)) begin
                got = 1'b1;
                break;
            end
            if (busy_of(i)) begin
                cur = abc_of(i);
                if (cur != 3'((n / 4) % 8)) seq_bad++;
                if (prev == 3'd7 && cur == 3'd0) wraps++;
                prev = cur;
                n++;
            end
            @(negedge clk);
        end
        start_v[i] = 1'b0;
        x = sb.pop_front();
        chk({tag, " done seen"}, 32'(got), 1);
        chk({tag, " busy cycles"}, n, x.busy_len);
        chk({tag, " vector order"}, seq_bad, 0);
        chk({tag, " wraps"}, wraps, x.wraps);
        chk({tag, " pass"}, 32'(pass_of(i)), 32'(x.pass));
        chk({tag, " err_count"}, 32'(errc_of(i)), 32'(x.errc));
        chk({tag, " first_err_valid"}, 32'(fval_of(i)), 32'(x.fvalid));
        chk({tag, " first_err_vec"}, 32'(fev_of(i)), 32'(x.fev));
        @(negedge clk);
        chk({tag, " done width"}, 32'(done_of(i)), 0);
        chk({tag, " idle busy"}, 32'(busy_of(i)), 0);
        chk({tag, " idle abc"}, 32'(abc_of(i)), 0);
        chk({tag, " pass held"}, 32'(pass_of(i)), 32'(x.pass));
    endtask

    initial begin
        int  k;
        bit  seen;
        rst_n   = 1'b0;
        start_v = '0;
        abort   = 1'b0;
        ymode   = '{0, 0, 0};
        repeat (2) @(negedge clk);
        chk_all_zero("reset", 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_check(0, -1, '{errc: 4'd0, fev: 3'd0, fvalid: 1'b0, pass: 1'b1, busy_len: 32, wraps: 0}, "golden");

        ymode[0] = 1;
        run_check(0, -1, '{errc: 4'd3, fev: 3'd0, fvalid: 1'b1, pass: 1'b0, busy_len: 32, wraps: 0}, "stuck0");

        ymode[1] = 2;
        run_check(1, -1, '{errc: 4'd3, fev: 3'd2, fvalid: 1'b1, pass: 1'b0, busy_len: 32, wraps: 0}, "stuck1_w2");

        run_check(2, -1, '{errc: 4'd0, fev: 3'd0, fvalid: 1'b0, pass: 1'b1, busy_len: 64, wraps: 1}, "two_pass");

        // Abort while vector 3 is on the outputs.
        ymode[0] = 0;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        k = 0;
        while (abc_of(0) != 3'd3 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("abort reach vec3", 32'(abc_of(0)), 3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort busy", 32'(busy0), 0);
        chk("abort abc", 32'({a0, b0, c0}), 0);
        chk("abort pass", 32'(pass0), 0);
        chk("abort err_count", 32'(errc0), 0);
        seen = 1'b0;
        for (int j = 0; j < 40; j++) begin
            if (done0) seen = 1'b1;
            @(negedge clk);
        end
        chk("abort no done", 32'(seen), 0);

        start_v[0] = 1'b1;
        abort      = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        abort      = 1'b0;
        chk("start+abort idle", 32'(busy0), 0);

        // Asynchronous reset in the middle of a failing run.
        ymode[0] = 1;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (14) @(negedge clk);
        chk("pre-reset err_count", 32'(errc0), 2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async reset", 0);
        ymode[0] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_check(0, -1, '{errc: 4'd0, fev: 3'd0, fvalid: 1'b0, pass: 1'b1, busy_len: 32, wraps: 0}, "post_reset");

        run_check(0, 10, '{errc: 4'd0, fev: 3'd0, fvalid: 1'b0, pass: 1'b1, busy_len: 32, wraps: 0}, "repulse");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
